// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl
//   Bus-side responder for a two-core snooping data-cache pair. It arbitrates
//   write-back words and miss fills onto the single RAM port, and snoops the
//   cache that did not make the request. A fill comes from RAM, or directly from
//   the snooped cache when that cache holds the block dirty. In that case the
//   block is also written through to RAM.
//
// Ports
//   CLK, RST          clock; synchronous active-high reset
//   dREN, dWEN        per-cache read / write word requests
//   daddr, dstore     per-cache word address / write data
//   cctrans, ccwrite  per-cache coherence transaction and write-intent / dirty flags
//   dwait             per-cache hold (low for one cycle per completed word)
//   dload             per-cache fill data
//   ccwait, ccinv     per-cache snoop-freeze and invalidate requests
//   ccsnoopaddr       per-cache snoop address (block aligned)
//   ramREN, ramWEN    RAM strobes (mutually exclusive)
//   ramaddr, ramstore RAM address / write data
//   ramload, ramstate RAM read data / status (FREE, BUSY, ACCESS, ERROR)

module coherence_bus_ctrl #(
    parameter int CPUS = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CPUS-1:0]           dREN,
    input  logic [CPUS-1:0]           dWEN,
    input  logic [CPUS-1:0][31:0]     daddr,
    input  logic [CPUS-1:0][31:0]     dstore,
    input  logic [CPUS-1:0]           cctrans,
    input  logic [CPUS-1:0]           ccwrite,
    output logic [CPUS-1:0]           dwait,
    output logic [CPUS-1:0][31:0]     dload,
    output logic [CPUS-1:0]           ccwait,
    output logic [CPUS-1:0]           ccinv,
    output logic [CPUS-1:0][31:0]     ccsnoopaddr,
    output logic                      ramREN,
    output logic                      ramWEN,
    output logic [31:0]               ramaddr,
    output logic [31:0]               ramstore,
    input  logic [31:0]               ramload,
    input  logic [1:0]                ramstate
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StWb    = 3'd1;
    localparam logic [2:0] StSnoop = 3'd2;
    localparam logic [2:0] StC2c1  = 3'd3;
    localparam logic [2:0] StC2c2  = 3'd4;
    localparam logic [2:0] StMem1  = 3'd5;
    localparam logic [2:0] StMem2  = 3'd6;

    localparam logic [1:0] RamAccess = 2'd2;

    logic [2:0]  state_q, state_d;
    logic        req_q, req_d;
    logic        rr_q, rr_d;
    logic [31:0] snoopaddr_q, snoopaddr_d;
    logic        inv_q, inv_d;
    // Set when the current miss snoops the other cache. It is clear for
    // non-coherent reads, which go straight to RAM with no snoop.
    logic        coh_q, coh_d;

    logic        snp;
    logic        access;
    logic [1:0]  elig;
    logic        pick;

    assign snp    = ~req_q;
    assign access = (ramstate == RamAccess);
    // WB (dWEN && !dREN) and any dREN are both grantable. The two are
    // disjoint, so WB over MISS within one cache needs no extra priority.
    assign elig   = dREN | dWEN;
    assign pick   = elig[rr_q] ? rr_q : ~rr_q;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rr_d        = rr_q;
        snoopaddr_d = snoopaddr_q;
        inv_d       = inv_q;
        coh_d       = coh_q;
        unique case (state_q)
            StIdle: begin
                if (|elig) begin
                    req_d = pick;
                    if (dWEN[pick] && !dREN[pick]) begin
                        state_d = StWb;
                        coh_d   = 1'b0;
                        inv_d   = 1'b0;
                    end else begin
                        snoopaddr_d = {daddr[pick][31:3], 3'b000};
                        if (cctrans[pick]) begin
                            state_d = StSnoop;
                            coh_d   = 1'b1;
                            inv_d   = ccwrite[pick];
                        end else begin
                            state_d = StMem1;
                            coh_d   = 1'b0;
                            inv_d   = 1'b0;
                        end
                    end
                end
            end
            StWb: begin
                if (access) begin
                    state_d = StIdle;
                    rr_d    = ~req_q;
                end
            end
            StSnoop: begin
                if (cctrans[snp]) begin
                    state_d = ccwrite[snp] ? StC2c1 : StMem1;
                end
            end
            StC2c1: begin
                if (access) state_d = StC2c2;
            end
            StMem1: begin
                if (access) state_d = StMem2;
            end
            StC2c2, StMem2: begin
                if (access) begin
                    state_d = StIdle;
                    rr_d    = ~req_q;
                    coh_d   = 1'b0;
                    inv_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                coh_d   = 1'b0;
                inv_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            req_q       <= 1'b0;
            rr_q        <= 1'b0;
            snoopaddr_q <= '0;
            inv_q       <= 1'b0;
            coh_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            rr_q        <= rr_d;
            snoopaddr_q <= snoopaddr_d;
            inv_q       <= inv_d;
            coh_q       <= coh_d;
        end
    end

    // Outputs are forced to their idle values while RST is high, so a
    // transaction aborted by reset issues no strobe in the reset cycle.
    always_comb begin
        dwait       = '1;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        if (!RST) begin
            if (state_q != StIdle && state_q != StWb && coh_q) begin
                ccwait[snp]      = 1'b1;
                ccinv[snp]       = inv_q;
                ccsnoopaddr[snp] = snoopaddr_q;
            end
            unique case (state_q)
                StWb: begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[req_q];
                    ramstore = dstore[req_q];
                    if (access) dwait[req_q] = 1'b0;
                end
                StC2c1, StC2c2: begin
                    // The dirty owner writes its block back while the
                    // requester takes the same words as its fill.
                    ramWEN       = 1'b1;
                    ramaddr      = daddr[snp];
                    ramstore     = dstore[snp];
                    dload[req_q] = dstore[snp];
                    if (access) dwait = 2'b00;
                end
                StMem1, StMem2: begin
                    ramREN       = 1'b1;
                    ramaddr      = daddr[req_q];
                    dload[req_q] = ramload;
                    if (access) dwait[req_q] = 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl. Inputs change 1 time unit after the
// rising edge. Outputs are sampled 1 time unit after that.

module tb_coherence_bus_ctrl;

    logic             CLK;
    logic             RST;
    logic [1:0]       dREN, dWEN, cctrans, ccwrite;
    logic [1:0][31:0] daddr, dstore;
    logic [1:0]       dwait, ccwait, ccinv;
    logic [1:0][31:0] dload, ccsnoopaddr;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    logic [1:0]       ramstate;

    int checks;
    int failures;

    coherence_bus_ctrl #(.CPUS(2)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .daddr       (daddr),
        .dstore      (dstore),
        .cctrans     (cctrans),
        .ccwrite     (ccwrite),
        .dwait       (dwait),
        .dload       (dload),
        .ccwait      (ccwait),
        .ccinv       (ccinv),
        .ccsnoopaddr (ccsnoopaddr),
        .ramREN      (ramREN),
        .ramWEN      (ramWEN),
        .ramaddr     (ramaddr),
        .ramstore    (ramstore),
        .ramload     (ramload),
        .ramstate    (ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        dREN     = '0;
        dWEN     = '0;
        cctrans  = '0;
        ccwrite  = '0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = 2'd0;
    endtask

    // Called with the DUT in SNOOP for cache w (or about to ack). The snooper
    // acks clean, then RAM returns two words in consecutive ACCESS cycles.
    task automatic serve_miss(input int w, input logic [31:0] d0, input logic [31:0] d1);
        logic       keep;
        logic [1:0] dw_exp;
        keep       = cctrans[1-w];
        cctrans[1-w] = 1'b1;
        ccwrite[1-w] = 1'b0;
        tick();
        cctrans[1-w] = keep;
        dw_exp     = (w == 0) ? 2'b10 : 2'b01;
        ramstate   = 2'd2;
        ramload    = d0;
        #1;
        check_val("miss_w0_ren", ramREN, 1);
        check_val("miss_w0_dload", dload[w], d0);
        check_val("miss_w0_dwait", dwait, dw_exp);
        tick();
        ramload = d1;
        #1;
        check_val("miss_w1_dload", dload[w], d1);
        check_val("miss_w1_dwait", dwait, dw_exp);
        tick();
        dREN[w]    = 1'b0;
        cctrans[w] = 1'b0;
        ramstate   = 2'd0;
        #1;
        check_val("miss_done_ccwait", ccwait, 0);
        check_val("miss_done_ren", ramREN, 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear_inputs();
        RST = 1'b1;

        // Reset state
        tick();
        tick();
        check_val("rst_dwait", dwait, 2'b11);
        check_val("rst_ccwait", ccwait, 0);
        check_val("rst_strobes", {ramREN, ramWEN}, 0);
        check_val("rst_ramaddr", ramaddr, 0);
        check_val("rst_dload0", dload[0], 0);
        RST = 1'b0;

        // Single WB: cache0, two BUSY cycles then ACCESS
        dWEN[0]   = 1'b1;
        daddr[0]  = 32'h100;
        dstore[0] = 32'hDEADBEEF;
        ramstate  = 2'd1;
        #1;
        check_val("wb_idle_dwait", dwait, 2'b11);
        check_val("wb_idle_wen", ramWEN, 0);
        tick();
        check_val("wb_wen", ramWEN, 1);
        check_val("wb_ren", ramREN, 0);
        check_val("wb_addr", ramaddr, 32'h100);
        check_val("wb_store", ramstore, 32'hDEADBEEF);
        check_val("wb_busy_dwait", dwait, 2'b11);
        tick();
        check_val("wb_busy2_dwait", dwait, 2'b11);
        tick();
        ramstate = 2'd2;
        #1;
        check_val("wb_access_dwait", dwait, 2'b10);
        tick();
        dWEN[0]  = 1'b0;
        ramstate = 2'd0;
        #1;
        check_val("wb_done_dwait", dwait, 2'b11);
        check_val("wb_done_wen", ramWEN, 0);

        // Clean miss: cache1 at 0x208, cache0 snooped and acks clean (rr=1)
        dREN[1]    = 1'b1;
        cctrans[1] = 1'b1;
        daddr[1]   = 32'h208;
        tick();
        check_val("cm_ccwait", ccwait, 2'b01);
        check_val("cm_snoopaddr", ccsnoopaddr[0], 32'h208);
        check_val("cm_ccinv", ccinv, 0);
        check_val("cm_snoop_ren", ramREN, 0);
        check_val("cm_snoop_dwait", dwait, 2'b11);
        tick();
        check_val("cm_dwell_ccwait", ccwait, 2'b01);
        serve_miss(1, 32'h11, 32'h22);

        // Dirty C2C: cache0 write-miss at 0x300, cache1 supplies 0xAA/0xBB (rr=0)
        dREN[0]    = 1'b1;
        cctrans[0] = 1'b1;
        ccwrite[0] = 1'b1;
        daddr[0]   = 32'h300;
        tick();
        check_val("c2c_ccinv", ccinv, 2'b10);
        check_val("c2c_ccwait", ccwait, 2'b10);
        check_val("c2c_snoopaddr", ccsnoopaddr[1], 32'h300);
        cctrans[1] = 1'b1;
        ccwrite[1] = 1'b1;
        tick();
        ccwrite[0] = 1'b0;
        dWEN[1]    = 1'b1;
        daddr[1]   = 32'h300;
        dstore[1]  = 32'hAA;
        ramstate   = 2'd1;
        #1;
        check_val("c2c_inv_held", ccinv, 2'b10);
        check_val("c2c_busy_wen", ramWEN, 1);
        check_val("c2c_busy_dwait", dwait, 2'b11);
        tick();
        ramstate = 2'd2;
        #1;
        check_val("c2c_w0_dwait", dwait, 2'b00);
        check_val("c2c_w0_dload", dload[0], 32'hAA);
        check_val("c2c_w0_store", ramstore, 32'hAA);
        check_val("c2c_w0_addr", ramaddr, 32'h300);
        tick();
        daddr[1]  = 32'h304;
        dstore[1] = 32'hBB;
        #1;
        check_val("c2c_w1_dwait", dwait, 2'b00);
        check_val("c2c_w1_dload", dload[0], 32'hBB);
        check_val("c2c_w1_store", ramstore, 32'hBB);
        check_val("c2c_w1_addr", ramaddr, 32'h304);
        tick();
        clear_inputs();
        #1;
        check_val("c2c_done_ccinv", ccinv, 0);
        check_val("c2c_done_ccwait", ccwait, 0);
        check_val("c2c_done_wen", ramWEN, 0);

        // Simultaneous misses with rr=1: cache1 first, then cache0
        dREN     = 2'b11;
        cctrans  = 2'b11;
        daddr[0] = 32'h400;
        daddr[1] = 32'h500;
        tick();
        check_val("sim1_first_ccwait", ccwait, 2'b01);
        check_val("sim1_first_snoop", ccsnoopaddr[0], 32'h500);
        serve_miss(1, 32'h55, 32'h56);
        check_val("sim1_gap_dwait", dwait, 2'b11);
        tick();
        check_val("sim1_second_ccwait", ccwait, 2'b10);
        check_val("sim1_second_snoop", ccsnoopaddr[1], 32'h400);
        serve_miss(0, 32'h44, 32'h45);

        // WB from cache1 with ERROR for 5 cycles (rr=1, then flips to 0)
        dWEN[1]   = 1'b1;
        daddr[1]  = 32'h600;
        dstore[1] = 32'h12345678;
        ramstate  = 2'd3;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_val("err_dwait", dwait, 2'b11);
            check_val("err_wen", ramWEN, 1);
            tick();
        end
        ramstate = 2'd2;
        #1;
        check_val("err_access_dwait", dwait, 2'b01);
        check_val("err_access_store", ramstore, 32'h12345678);
        tick();
        clear_inputs();

        // Simultaneous misses with rr=0: cache0 first, then cache1
        dREN     = 2'b11;
        cctrans  = 2'b11;
        daddr[0] = 32'h700;
        daddr[1] = 32'h800;
        tick();
        check_val("sim0_first_ccwait", ccwait, 2'b10);
        check_val("sim0_first_snoop", ccsnoopaddr[1], 32'h700);
        serve_miss(0, 32'h77, 32'h78);
        tick();
        check_val("sim0_second_ccwait", ccwait, 2'b01);
        check_val("sim0_second_snoop", ccsnoopaddr[0], 32'h800);
        serve_miss(1, 32'h88, 32'h89);

        // Non-coherent read on cache1, reset asserted in MEM2
        dREN[1]  = 1'b1;
        daddr[1] = 32'h900;
        tick();
        ramstate = 2'd2;
        #1;
        check_val("nc_ccwait", ccwait, 0);
        check_val("nc_ren", ramREN, 1);
        check_val("nc_addr", ramaddr, 32'h900);
        tick();
        ramstate = 2'd1;
        RST      = 1'b1;
        #1;
        check_val("rstmid_strobes", {ramREN, ramWEN}, 0);
        check_val("rstmid_dwait", dwait, 2'b11);
        check_val("rstmid_addr", ramaddr, 0);
        tick();
        RST      = 1'b0;
        dREN     = 2'b00;
        ramstate = 2'd2;
        #1;
        check_val("rstpost_dwait", dwait, 2'b11);
        check_val("rstpost_ccwait", ccwait, 0);
        check_val("rstpost_strobes", {ramREN, ramWEN}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coherence_bus_ctrl.md
# coherence_bus_ctrl

Bus-side responder for the two-core snooping data-cache coherence interface. Sits between two dcaches' `caches_if` channels and the single RAM port. Arbitrates write-backs and miss fills, issues snoops (`ccwait`/`ccinv`/`ccsnoopaddr`) to the non-requesting cache, and sources fill data either from RAM or cache-to-cache when the snooped cache holds the block dirty.

## Interface
Parameters:
- `CPUS`, 2: number of caches. Only 2 is supported; index 0/1 selects the cache.

Ports (arrays indexed by cache):
- `CLK` in 1: single clock; everything changes on its rising edge.
- `RST` in 1: reset; synchronous, active-high.
- `dREN` in [1:0]: cache read request, one word per handshake.
- `dWEN` in [1:0]: cache write request, one word per handshake.
- `daddr` in [1:0][31:0]: word address per cache.
- `dstore` in [1:0][31:0]: write data per cache.
- `cctrans` in [1:0]: coherence transaction / snoop acknowledge.
- `ccwrite` in [1:0]: on a miss, the requester intends to write; while snooped, the cache holds the block dirty and will supply it.
- `dwait` out [1:0]: 1 = hold; 0 for exactly one cycle per completed word.
- `dload` out [1:0][31:0]: fill data to the requester.
- `ccwait` out [1:0]: snoop/freeze request to a cache.
- `ccinv` out [1:0]: invalidate the snooped block.
- `ccsnoopaddr` out [1:0][31:0]: snoop address.
- `ramREN`, `ramWEN` out 1: RAM read/write strobes; never both high.
- `ramaddr`, `ramstore` out 32: RAM address and write data.
- `ramload` in 32: RAM read data.
- `ramstate` in 2: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR. A word completes only when ACCESS; ERROR is treated as BUSY.

## Operation
- Request classes:
  - WB: `dWEN[i] && !dREN[i]` (eviction or flush word).
  - MISS: `dREN[i] && cctrans[i]`.
- Round-robin pointer `rr` (reset 0) names the preferred cache. `rr` flips to the other cache after every completed WB word and every completed MISS (after the second word). `rr` never flips on a snoop write-back.
- States: IDLE, WB, SNOOP, C2C1, C2C2, MEM1, MEM2. `req` is the granted cache; `snp = ~req`.
- IDLE:
  - Pick cache i, preferring `rr` when both are eligible. WB beats MISS within the same cache.
  - WB goes to WB. MISS goes to SNOOP, latching `req` and `snoopaddr = {daddr[req][31:3],3'b000}`.
- WB:
  - Drive `ramWEN=1`, `ramaddr=daddr[req]`, `ramstore=dstore[req]`.
  - On ACCESS: `dwait[req]=0` for that cycle, then go to IDLE.
- SNOOP, C2C and MEM states all hold `ccwait[snp]=1`, `ccsnoopaddr[snp]=snoopaddr` and `ccinv[snp]=ccwrite[req]` (ccinv sampled at SNOOP entry and held).
- SNOOP: wait for `cctrans[snp]`.
  - `ccwrite[snp]=1` goes to C2C1; otherwise it goes to MEM1.
  - Pure SNOOP dwell is capped by the snooper; there is no timeout.
- C2C1/C2C2 (dirty-owner supply; snooper does `dWEN` on offsets 0/4):
  - Drive `ramWEN=1`, `ramaddr=daddr[snp]`, `ramstore=dstore[snp]`, `dload[req]=dstore[snp]`.
  - On ACCESS, drop `dwait[snp]` and `dwait[req]` in the same cycle.
  - C2C1 advances to C2C2; C2C2 goes to IDLE.
- MEM1/MEM2:
  - Drive `ramREN=1`, `ramaddr=daddr[req]`, `dload[req]=ramload`.
  - On ACCESS, `dwait[req]=0`. MEM1 advances to MEM2; MEM2 goes to IDLE.
- Leaving MEM2/C2C2 deasserts `ccwait`/`ccinv` on the next edge.
- Boundaries:
  - Both caches miss the same cycle: `rr` winner is served; the loser keeps `dwait=1` and is snooped next.
  - A snooped cache's own pending request is ignored until `ccwait` drops.
  - `dREN` without `cctrans` (non-coherent read) is treated as MISS with no snoop: go straight to MEM1 with `ccwait=0`.

## Timing
- Reset values (held while RST=1):
  - State IDLE, `rr=0`.
  - `dwait=2'b11`; `ccwait`, `ccinv`, `ramREN`, `ramWEN` = 0.
  - All address/data outputs 0.
- Outputs are combinational from registered state plus the current RAM/cache inputs. `dwait` low is valid in the ACCESS cycle only.
- Minimum latencies:
  - WB word: 2 cycles from request (IDLE plus one ACCESS cycle).
  - Clean miss: IDLE, SNOOP ≥1 cycle, then 2 ACCESS cycles.
- RST asserted mid-transaction aborts immediately. No RAM strobe is issued in the reset cycle or after it.

## Test plan
- Single WB: cache0 `dWEN`, `daddr=0x100`, `dstore=0xDEADBEEF`, RAM ACCESS after 2 BUSY → `ramWEN` with those values, `dwait[0]` low for one cycle, `rr=1`.
- Clean miss: cache1 `dREN+cctrans`, `daddr=0x208`, snooper acks with `ccwrite=0`, RAM returns 0x11/0x22 → `ccwait[0]=1`, `ccsnoopaddr[0]=0x208`, `ccinv[0]=0`, and `dload[1]` shows 0x11 then 0x22.
- Dirty C2C with invalidate: cache0 miss with `ccwrite=1`, cache1 acks dirty and writes 0xAA/0xBB → `ccinv[1]=1`, `dload[0]=0xAA/0xBB`, RAM written identically, both `dwait` drop together.
- Simultaneous misses with `rr=0` → cache0 served first, then cache1 snooped. Repeat with `rr=1` → order reversed.
- RST asserted during MEM2 → next cycle `dwait=11`, `ccwait=0`, no RAM strobes, state IDLE.
- `ramstate=ERROR` for 5 cycles during WB → `dwait` stays high, and completes on the first ACCESS.
